// File: rtl/core_pkg.sv
// Shared types and constants for the core decode/execute boundary.
//   XLEN_32 / XLEN_64 : the only supported datapath widths
//   imm_type_e        : immediate format selector, full-width and RVC formats
//   is_rvc_type()     : true for the compressed immediate formats
package core_pkg;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

    typedef enum logic [3:0] {
        IMM_I    = 4'd0,
        IMM_S    = 4'd1,
        IMM_B    = 4'd2,
        IMM_U    = 4'd3,
        IMM_J    = 4'd4,
        IMM_CI   = 4'd5,
        IMM_CLUI = 4'd6,
        IMM_CIW  = 4'd7,
        IMM_CB   = 4'd8,
        IMM_CJ   = 4'd9,
        IMM_NONE = 4'd10
    } imm_type_e;

    function automatic logic is_rvc_type(input imm_type_e t);
        return t inside {IMM_CI, IMM_CLUI, IMM_CIW, IMM_CB, IMM_CJ};
    endfunction

endpackage

// File: rtl/core_imm_stage_if.sv
// Handshake bundle between decoder, immediate stage and ALU operand mux.
//   in_valid/in_ready/instr/imm_type  : decoder -> stage
//   out_valid/out_ready/out_imm/out_illegal : stage -> ALU
// master = decoder/ALU side, slave = the immediate stage.
interface core_imm_stage_if
    import core_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    imm_type_e       imm_type;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, instr, imm_type, out_ready,
        input  in_ready, out_valid, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, instr, imm_type, out_ready,
        output in_ready, out_valid, out_imm, out_illegal
    );
endinterface

// File: rtl/core_imm_extract.sv
// Combinational immediate extraction for RV32/RV64 with optional RVC formats.
//   instr    : raw instruction (compressed encodings in [15:0])
//   imm_type : format selector
//   imm      : immediate sign/zero-extended to XLEN, zero when illegal
//   illegal  : reserved-zero field, disabled RVC format or undefined type
module core_imm_extract
    import core_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_32,
    parameter bit          RVC_EN = 1'b1
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Every format is first sign/zero-extended to 32 bits; widening to 64
    // then only needs bit 31 (CIW keeps bit 31 clear, so it stays zero-extended).
    logic [31:0] imm32;
    logic        bad;
    logic        unused_instr;

    assign unused_instr = ^{instr[15:13], instr[1:0]};

    always_comb begin
        imm32 = '0;
        bad   = 1'b0;
        case (imm_type)
            IMM_I:    imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            IMM_U:    imm32 = {instr[31:12], 12'b0};
            IMM_J:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            IMM_CI:   imm32 = {{26{instr[12]}}, instr[12], instr[6:2]};
            IMM_CLUI: begin
                imm32 = {{14{instr[12]}}, instr[12], instr[6:2], 12'b0};
                bad   = ({instr[12], instr[6:2]} == 6'd0);
            end
            IMM_CIW:  begin
                imm32 = {22'b0, instr[10:7], instr[12:11], instr[5], instr[6], 2'b0};
                bad   = (instr[12:5] == 8'd0);
            end
            IMM_CB:   imm32 = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                               instr[11:10], instr[4:3], 1'b0};
            IMM_CJ:   imm32 = {{20{instr[12]}}, instr[12], instr[8], instr[10:9],
                               instr[6], instr[7], instr[2], instr[11], instr[5:3], 1'b0};
            default:  bad   = 1'b1;
        endcase
        if (is_rvc_type(imm_type) && !RVC_EN) begin
            bad = 1'b1;
        end
        if (bad) begin
            imm32 = '0;
        end
    end

    assign illegal = bad;

    generate
        if (XLEN == XLEN_64) begin : g_xlen64
            assign imm = {{32{imm32[31]}}, imm32};
        end else if (XLEN == XLEN_32) begin : g_xlen32
            assign imm = imm32;
        end else begin : g_xlen_bad
            $error("core_imm_extract: XLEN must be 32 or 64");
        end
    endgenerate

endmodule

// File: rtl/core_imm_stage.sv
// Registered, handshaked immediate stage with a two-entry skid buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous discard of both buffered entries
//   stg        : slave side of core_imm_stage_if (decoder in, ALU out)
// out_* always show the main entry; in_ready is a flop equal to !skid_valid.
module core_imm_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_32,
    parameter bit          RVC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    core_imm_stage_if.slave   stg
);

    logic [XLEN-1:0] new_imm;
    logic            new_illegal;

    logic            main_valid;
    logic [XLEN-1:0] main_imm;
    logic            main_illegal;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_illegal;
    logic            in_ready_q;

    logic            accept;
    logic            main_free;
    logic            skid_nxt;

    core_imm_extract #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_extract (
        .instr    (stg.instr),
        .imm_type (stg.imm_type),
        .imm      (new_imm),
        .illegal  (new_illegal)
    );

    assign accept    = stg.in_valid && in_ready_q;
    // Main can take new content this edge: empty, or being consumed.
    assign main_free = !main_valid || stg.out_ready;

    // Accept is impossible while the skid is occupied, so the skid either
    // drains into main or fills only when main is held by backpressure.
    always_comb begin
        skid_nxt = 1'b0;
        if (skid_valid) begin
            skid_nxt = !main_free;
        end else begin
            skid_nxt = accept && !main_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid   <= 1'b0;
            main_imm     <= '0;
            main_illegal <= 1'b0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            if (main_free) begin
                if (skid_valid) begin
                    main_valid   <= 1'b1;
                    main_imm     <= skid_imm;
                    main_illegal <= skid_illegal;
                end else if (accept) begin
                    main_valid   <= 1'b1;
                    main_imm     <= new_imm;
                    main_illegal <= new_illegal;
                end else begin
                    main_valid   <= 1'b0;
                end
            end
            if (accept && !main_free) begin
                skid_imm     <= new_imm;
                skid_illegal <= new_illegal;
            end
            skid_valid <= skid_nxt;
            in_ready_q <= !skid_nxt;
        end
    end

    assign stg.in_ready    = in_ready_q;
    assign stg.out_valid   = main_valid;
    assign stg.out_imm     = main_imm;
    assign stg.out_illegal = main_illegal;

endmodule

// File: tb/tb_core_imm_stage.sv
// Scoreboard bench for core_imm_stage: a 64-bit RVC-enabled instance and a
// 32-bit RVC-disabled instance receive identical stimulus.
module tb_core_imm_stage;
    import core_pkg::*;

    typedef struct {
        logic [63:0] imm;
        bit          ill;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   mode;        // out_ready: 0 random, 1 held low, 2 held high
    int   n_tests;
    int   n_fail;
    exp_t q0[$];
    exp_t q1[$];

    core_imm_stage_if #(.XLEN(64)) if0 ();
    core_imm_stage_if #(.XLEN(32)) if1 ();

    core_imm_stage #(.XLEN(64), .RVC_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stg(if0.slave)
    );
    core_imm_stage #(.XLEN(32), .RVC_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stg(if1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint sext(input longint v, input int w);
        longint s;
        s = v <<< (64 - w);
        return s >>> (64 - w);
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [3:0] t,
                                   input bit rvc, input int xlen);
        exp_t       e;
        logic [20:0] o;
        longint     v;
        bit         ill;
        o = '0; v = 0; ill = 0;
        case (imm_type_e'(t))
            IMM_I: v = sext(longint'(i[31:20]), 12);
            IMM_S: begin
                o[11:5] = i[31:25]; o[4:0] = i[11:7];
                v = sext(longint'(o), 12);
            end
            IMM_B: begin
                o[12] = i[31]; o[11] = i[7]; o[10:5] = i[30:25]; o[4:1] = i[11:8];
                v = sext(longint'(o), 13);
            end
            IMM_U: v = sext(longint'(i[31:12]) * 4096, 32);
            IMM_J: begin
                o[20] = i[31]; o[19:12] = i[19:12]; o[11] = i[20]; o[10:1] = i[30:21];
                v = sext(longint'(o), 21);
            end
            IMM_CI: begin
                o[5] = i[12]; o[4:0] = i[6:2];
                v = sext(longint'(o), 6);
            end
            IMM_CLUI: begin
                o[5] = i[12]; o[4:0] = i[6:2];
                ill = (o == 0);
                v = sext(longint'(o), 6) * 4096;
            end
            IMM_CIW: begin
                o[5:4] = i[12:11]; o[9:6] = i[10:7]; o[2] = i[6]; o[3] = i[5];
                ill = (o == 0);
                v = longint'(o);
            end
            IMM_CB: begin
                o[8] = i[12]; o[4:3] = i[11:10]; o[7:6] = i[6:5]; o[2:1] = i[4:3]; o[5] = i[2];
                v = sext(longint'(o), 9);
            end
            IMM_CJ: begin
                o[11] = i[12]; o[4] = i[11]; o[9:8] = i[10:9]; o[10] = i[8];
                o[6] = i[7]; o[7] = i[6]; o[3:1] = i[5:3]; o[5] = i[2];
                v = sext(longint'(o), 12);
            end
            default: ill = 1;
        endcase
        if (!rvc && t >= 4'(IMM_CI) && t <= 4'(IMM_CJ)) ill = 1;
        e.ill = ill;
        if (ill) e.imm = '0;
        else if (xlen == 32) e.imm = {32'b0, v[31:0]};
        else e.imm = 64'(v);
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed entry must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && flush === 1'b0 && if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d0_unexpected: got imm 0x%0h expected no output", if0.out_imm);
            end else begin
                e = q0.pop_front();
                chk("d0_imm", if0.out_imm, e.imm);
                chk("d0_ill", {63'b0, if0.out_illegal}, {63'b0, e.ill});
            end
        end
        if (rst_n === 1'b1 && flush === 1'b0 && if1.out_valid === 1'b1 && if1.out_ready === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d1_unexpected: got imm 0x%0h expected no output", if1.out_imm);
            end else begin
                e = q1.pop_front();
                chk("d1_imm", {32'b0, if1.out_imm}, e.imm);
                chk("d1_ill", {63'b0, if1.out_illegal}, {63'b0, e.ill});
            end
        end
    end

    // out_ready driver
    initial begin
        logic r;
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       r = 1'($urandom_range(0, 1));
                1:       r = 1'b0;
                default: r = 1'b1;
            endcase
            if0.out_ready = r;
            if1.out_ready = r;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] t);
        if0.in_valid = v; if0.instr = ins; if0.imm_type = imm_type_e'(t);
        if1.in_valid = v; if1.instr = ins; if1.imm_type = imm_type_e'(t);
    endtask

    task automatic set_mode(input int m);
        mode = m;
        @(posedge clk);
        #2;
    endtask

    // Offers one entry, waits for acceptance (bounded), returns #1 after the accept edge.
    task automatic offer(input logic [31:0] ins, input logic [3:0] t, input bit use_c,
                         input logic [63:0] c0, input bit l0,
                         input logic [63:0] c1, input bit l1);
        exp_t e0, e1;
        if (use_c) begin
            e0.imm = c0; e0.ill = l0;
            e1.imm = c1; e1.ill = l1;
        end else begin
            e0 = model(ins, t, 1'b1, 64);
            e1 = model(ins, t, 1'b0, 32);
        end
        drive(1'b1, ins, t);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if0.in_ready === 1'b1) begin
                q0.push_back(e0);
                q1.push_back(e1);
                @(posedge clk);
                #1;
                drive(1'b0, ins, t);
                return;
            end
            @(posedge clk);
            #1;
        end
        n_tests++; n_fail++;
        $display("FAIL offer_timeout: got in_ready 0 expected 1 within 200 cycles");
        drive(1'b0, ins, t);
    endtask

    task automatic drain();
        int k;
        mode = 2;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
        @(posedge clk);
        #1;
        chk("drain_empty0", {63'b0, if0.out_valid}, 64'd0);
        chk("drain_empty1", {63'b0, if1.out_valid}, 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid0"}, {63'b0, if0.out_valid}, 64'd0);
        chk({tag, "_ill0"},   {63'b0, if0.out_illegal}, 64'd0);
        chk({tag, "_imm0"},   if0.out_imm, 64'd0);
        chk({tag, "_rdy0"},   {63'b0, if0.in_ready}, 64'd1);
        chk({tag, "_valid1"}, {63'b0, if1.out_valid}, 64'd0);
        chk({tag, "_imm1"},   {32'b0, if1.out_imm}, 64'd0);
        chk({tag, "_rdy1"},   {63'b0, if1.in_ready}, 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ins;
        logic [3:0]  t;
        n_tests = 0; n_fail = 0;
        mode = 1;
        rst_n = 1'b0; flush = 1'b0;
        drive(1'b0, 32'h0, 4'(IMM_NONE));
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // I-type with single-cycle latency under out_ready=0
        set_mode(1);
        offer(32'hFFF00093, 4'(IMM_I), 1, 64'hFFFFFFFFFFFFFFFF, 0, 64'hFFFFFFFF, 0);
        chk("lat_valid0", {63'b0, if0.out_valid}, 64'd1);
        chk("lat_valid1", {63'b0, if1.out_valid}, 64'd1);
        drain();

        // directed formats, back-to-back with out_ready high
        set_mode(2);
        offer(32'hFE000EE3, 4'(IMM_B),   1, 64'hFFFFFFFFFFFFFFFC, 0, 64'hFFFFFFFC, 0);
        offer(32'h12345037, 4'(IMM_U),   1, 64'h0000000012345000, 0, 64'h12345000, 0);
        offer(32'h80000037, 4'(IMM_U),   1, 64'hFFFFFFFF80000000, 0, 64'h80000000, 0);
        offer(32'h0000A009, 4'(IMM_CJ),  1, 64'h2, 0, 64'h0, 1);
        offer(32'h00000000, 4'(IMM_CIW), 1, 64'h0, 1, 64'h0, 1);
        offer(32'h00001004, 4'(IMM_CI),  1, 64'hFFFFFFFFFFFFFFE1, 0, 64'h0, 1);
        offer(32'h00001004, 4'(IMM_NONE), 1, 64'h0, 1, 64'h0, 1);
        offer(32'h00001004, 4'd15,       1, 64'h0, 1, 64'h0, 1);
        drain();

        // backpressure: A, B accepted, C held until out_ready rises
        set_mode(1);
        offer(32'h00100093, 4'(IMM_I), 0, 0, 0, 0, 0);
        chk("bp_rdy_after_A", {63'b0, if0.in_ready}, 64'd1);
        offer(32'h00200093, 4'(IMM_I), 0, 0, 0, 0, 0);
        chk("bp_rdy_after_B", {63'b0, if0.in_ready}, 64'd0);
        drive(1'b1, 32'h00300093, 4'(IMM_I));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_rdy", {63'b0, if0.in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        mode = 2;
        offer(32'h00300093, 4'(IMM_I), 0, 0, 0, 0, 0);
        drain();

        // flush in ONE overrides a same-cycle accept
        set_mode(1);
        offer(32'h00400093, 4'(IMM_I), 0, 0, 0, 0, 0);
        drive(1'b1, 32'h7FF00093, 4'(IMM_I));
        flush = 1'b1;
        @(negedge clk);
        chk("fl1_rdy_before", {63'b0, if0.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'(IMM_I));
        q0.delete(); q1.delete();
        chk("fl1_valid", {63'b0, if0.out_valid}, 64'd0);
        chk("fl1_rdy", {63'b0, if0.in_ready}, 64'd1);

        // flush in FULL with an offered entry
        offer(32'h00500093, 4'(IMM_I), 0, 0, 0, 0, 0);
        offer(32'h00600093, 4'(IMM_I), 0, 0, 0, 0, 0);
        drive(1'b1, 32'h7FE00093, 4'(IMM_I));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'(IMM_I));
        q0.delete(); q1.delete();
        chk("fl2_valid0", {63'b0, if0.out_valid}, 64'd0);
        chk("fl2_valid1", {63'b0, if1.out_valid}, 64'd0);
        chk("fl2_rdy", {63'b0, if0.in_ready}, 64'd1);
        mode = 2;
        repeat (4) @(posedge clk);
        #1;

        // asynchronous reset between edges with two entries buffered
        set_mode(1);
        offer(32'h00700093, 4'(IMM_I), 0, 0, 0, 0, 0);
        offer(32'hFFF00093, 4'(IMM_I), 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        chk_reset_state("areset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(32'h00800093, 4'(IMM_I), 0, 0, 0, 0, 0);
        chk("post_rst_valid", {63'b0, if0.out_valid}, 64'd1);
        drain();

        // randomized traffic with random backpressure
        set_mode(0);
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0:       ins = ins & ~32'h0000107C;
                1:       ins = ins & ~32'h00001FE0;
                default: ;
            endcase
            t = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            offer(ins, t, 0, 0, 0, 0, 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
